// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, counter sizing.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MD_MADD_EN.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NOP   = 4'h0,
    MD_MULT  = 4'h1,
    MD_MULTU = 4'h2,
    MD_DIV   = 4'h3,
    MD_DIVU  = 4'h4,
    MD_MTHI  = 4'h5,
    MD_MTLO  = 4'h6,
    MD_MFHI  = 4'h7,
    MD_MFLO  = 4'h8,
    MD_MADD  = 4'h9,
    MD_MADDU = 4'hA,
    MD_MSUB  = 4'hB,
    MD_MSUBU = 4'hC
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DFLT = 5;
  localparam int DIV_CYCLES_DFLT  = 10;

  // Counter must hold N-1 for the longer latency; never narrower than one bit.
  function automatic int cnt_width(input int m, input int d);
    int mx;
    mx = (m > d) ? m : d;
    return (mx > 1) ? $clog2(mx) : 1;
  endfunction

  localparam int CNT_W = cnt_width(MULT_CYCLES_DFLT, DIV_CYCLES_DFLT);

  function automatic logic is_mult_op(input logic [3:0] op);
    logic r;
    case (op)
      MD_MULT, MD_MULTU: r = 1'b1;
`ifdef MD_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_if.sv
// E-stage request/response bundle between the pipeline and the multiply/divide unit.
interface md_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] result;

  modport master (output start, op, src_a, src_b, cancel,
                  input  busy, hi, lo, result);
  modport slave  (input  start, op, src_a, src_b, cancel,
                  output busy, hi, lo, result);
endinterface

// File: rtl/md_arith.sv
// Combinational 64-bit product and 32-bit quotient/remainder, including the
// divide-by-zero and INT_MIN/-1 corner cases.
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod,
  output logic [63:0] divres
);

  logic        mul_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [31:0] quot;
  logic [31:0] rem;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    mul_signed = (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB);
    a_ext      = mul_signed ? {{32{a[31]}}, a} : {32'h0, a};
    b_ext      = mul_signed ? {{32{b[31]}}, b} : {32'h0, b};
    // Low 64 bits of the extended product are exact for both signednesses.
    prod       = a_ext * b_ext;

    quot = '1;
    rem  = a;
    if (b == 32'h0) begin
      quot = '1;
      rem  = a;
    end else if (op == MD_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        quot = 32'h8000_0000;
        rem  = 32'h0;
      end else begin
        quot = $signed(a) / $signed(b);
        rem  = $signed(a) % $signed(b);
      end
    end else begin
      quot = a / b;
      rem  = a % b;
    end
    divres = {rem, quot};
  end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with HI/LO and fixed multi-cycle latency.
// Define MD_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DFLT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DFLT
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);

  localparam int CNT_WIDTH = cnt_width(MULT_CYCLES, DIV_CYCLES);

  md_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic [31:0]          hi_q, hi_d;
  logic [31:0]          lo_q, lo_d;
  logic [63:0]          pend_q, pend_d;

  logic                 launch;
  logic [63:0]          prod;
  logic [63:0]          divres;
  logic [63:0]          pend_new;

  md_arith u_arith (
    .op     (bus.op),
    .a      (bus.src_a),
    .b      (bus.src_b),
    .prod   (prod),
    .divres (divres)
  );

  always_comb begin
    pend_new = prod;
    case (bus.op)
      MD_DIV, MD_DIVU: pend_new = divres;
`ifdef MD_MADD_EN
      // Accumulate against HI/LO as they stand at launch.
      MD_MADD, MD_MADDU: pend_new = {hi_q, lo_q} + prod;
      MD_MSUB, MD_MSUBU: pend_new = {hi_q, lo_q} - prod;
`endif
      default: pend_new = prod;
    endcase
  end

  assign launch = bus.start & ~bus.cancel & ~busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          if (is_mult_op(bus.op)) begin
            state_d = BUSY;
            busy_d  = 1'b1;
            cnt_d   = CNT_WIDTH'(MULT_CYCLES - 1);
            pend_d  = pend_new;
          end else if (is_div_op(bus.op)) begin
            state_d = BUSY;
            busy_d  = 1'b1;
            cnt_d   = CNT_WIDTH'(DIV_CYCLES - 1);
            pend_d  = pend_new;
          end else if (bus.op == MD_MTHI) begin
            hi_d = bus.src_a;
          end else if (bus.op == MD_MTLO) begin
            lo_d = bus.src_a;
          end
        end
      end
      BUSY: begin
        // cancel is deliberately ignored here: the in-flight op already retired past E.
        if (cnt_q == '0) begin
          {hi_d, lo_d} = pend_q;
          state_d      = IDLE;
          busy_d       = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.result = (bus.op == MD_MFHI) ? hi_q : lo_q;

endmodule
